// File: rtl/psum_drain_pkg.sv
// Shared types and sizing for the partial-sum drain: FSM state encoding,
// output byte width, pack factor and derived word/FIFO entry widths.
package psum_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } drain_state_t;

    localparam int OUT_BYTE_W  = 8;
    localparam int PACK_FACTOR = 4;
    localparam int WORD_W      = OUT_BYTE_W * PACK_FACTOR;
    localparam int ADDR_W      = 16;
    localparam int LANE_W      = $clog2(PACK_FACTOR);
    localparam int ENTRY_W     = 1 + ADDR_W + WORD_W;

endpackage

// File: rtl/psum_drain_if.sv
// Output word bus from the drain to the output memory writer (valid/ready).
interface psum_drain_if;
    import psum_drain_pkg::*;

    logic [WORD_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output m_data,
        output m_addr,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_addr,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/psum_drain_fifo.sv
// Synchronous register FIFO for packed output words {last, addr, data}.
// Overflowing pushes and underflowing pops are dropped.
module drain_fifo #(
    parameter int depth = 4,
    parameter int width = 49
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] wdata,
    input  logic             pop,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(depth);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(depth);

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Drains a ReLU'd partial-sum tile: requantizes each element to a byte, packs
// up to four bytes per row-aligned word and streams {addr, data, last} out.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; input stalled
//   ST_RUN   | accepting elements, packing and pushing words
//   ST_FLUSH | last word pushed; waiting for its handshake
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int data_width = 25,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4:0]            cfg_shift,
    input  logic [7:0]            cfg_row_len,
    input  logic [7:0]            cfg_num_rows,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    psum_drain_if.master          m
);

    drain_state_t state_q;
    drain_state_t state_d;

    logic [4:0]            shift_q;
    logic [7:0]            row_len_q;
    logic [7:0]            num_rows_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [LANE_W-1:0]     lane_q;
    logic [7:0]            col_q;
    logic [7:0]            row_q;
    logic [WORD_W-1:0]     accum_q;

    logic [data_width-1:0] shifted;
    logic [OUT_BYTE_W-1:0] q_byte;
    logic [WORD_W-1:0]     word_next;
    logic                  accept;
    logic                  row_end;
    logic                  tile_end;
    logic                  word_end;
    logic                  push;
    logic                  pop;
    logic                  pop_last;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_wdata;
    logic [ENTRY_W-1:0]    fifo_head;

    // Negative sums cannot reach here legally; a set MSB is forced to zero.
    assign shifted = in_data >> shift_q;
    assign q_byte  = in_data[data_width-1]                   ? '0 :
                     (|shifted[data_width-1:OUT_BYTE_W])     ? {OUT_BYTE_W{1'b1}} :
                                                               shifted[OUT_BYTE_W-1:0];

    assign accept   = in_valid && !stall;
    assign row_end  = (col_q == row_len_q - 8'd1);
    assign tile_end = row_end && (row_q == num_rows_q - 8'd1);
    assign word_end = (lane_q == LANE_W'(PACK_FACTOR - 1)) || row_end;
    assign push     = accept && word_end;

    // Lanes above the current one are still zero in the accumulator, so a
    // row-ending partial word comes out with clean upper lanes.
    always_comb begin
        word_next = accum_q;
        word_next[{lane_q, 3'b000} +: OUT_BYTE_W] = q_byte;
    end

    assign fifo_wdata = {tile_end, addr_q, word_next};

    drain_fifo #(
        .depth (fifo_depth),
        .width (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m.m_valid = !fifo_empty;
    assign m.m_data  = fifo_head[WORD_W-1:0];
    assign m.m_addr  = fifo_head[WORD_W +: ADDR_W];
    assign m.m_last  = fifo_head[ENTRY_W-1] && !fifo_empty;
    assign pop       = m.m_valid && m.m_ready;
    assign pop_last  = pop && m.m_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        stall   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                stall = fifo_full;
                if (push && tile_end) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (pop_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q    <= '0;
            row_len_q  <= '0;
            num_rows_q <= '0;
            addr_q     <= '0;
            lane_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            accum_q    <= '0;
            done       <= 1'b0;
        end else begin
            done <= (state_q == ST_FLUSH) && pop_last;
            if ((state_q == ST_IDLE) && start) begin
                shift_q    <= cfg_shift;
                row_len_q  <= cfg_row_len;
                num_rows_q <= cfg_num_rows;
                addr_q     <= cfg_base_addr;
                lane_q     <= '0;
                col_q      <= '0;
                row_q      <= '0;
                accum_q    <= '0;
            end else if (accept) begin
                if (word_end) begin
                    accum_q <= '0;
                    lane_q  <= '0;
                    addr_q  <= addr_q + 1'b1;
                end else begin
                    accum_q <= word_next;
                    lane_q  <= lane_q + 1'b1;
                end
                if (row_end) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: packing, partial words, quantization,
// back-pressure, address wrap, mid-tile reset.
module tb_psum_drain;
    import psum_drain_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  cfg_shift = '0;
    logic [7:0]  cfg_row_len = '0;
    logic [7:0]  cfg_num_rows = '0;
    logic [15:0] cfg_base_addr = '0;
    logic [24:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        stall;
    logic        busy;
    logic        done;

    psum_drain_if bus ();

    psum_drain #(.data_width(25), .fifo_depth(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_shift     (cfg_shift),
        .cfg_row_len   (cfg_row_len),
        .cfg_num_rows  (cfg_num_rows),
        .cfg_base_addr (cfg_base_addr),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .stall         (stall),
        .busy          (busy),
        .done          (done),
        .m             (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_hs_cyc = 0;
    int prev;
    logic [48:0] wq [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) begin
            wq.push_back({bus.m_last, bus.m_addr, bus.m_data});
            if (bus.m_last) last_hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input int idx, input logic l, input logic [15:0] a, input logic [31:0] d);
        logic [48:0] got;
        got = (idx < wq.size()) ? wq[idx] : 'x;
        chk($sformatf("word%0d", idx), {15'd0, got}, {15'd0, l, a, d});
    endtask

    task automatic do_start(input logic [4:0] sh, input logic [7:0] rl, input logic [7:0] nr,
                            input logic [15:0] base);
        cfg_shift     = sh;
        cfg_row_len   = rl;
        cfg_num_rows  = nr;
        cfg_base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [24:0] d);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = !stall;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("accept", acc, 1'b1);
    endtask

    task automatic wait_done(input int p);
        int n;
        n = 0;
        while (done_cnt == p && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - p, 1);
    endtask

    initial begin
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // two full words, ignored start mid-tile, 1-cycle latency
        bus.m_ready = 1'b1;
        wq.delete();
        prev = done_cnt;
        do_start(5'd0, 8'd8, 8'd1, 16'h0100);
        chk("t1_busy", busy, 1);
        chk("t1_stall", stall, 0);
        for (int i = 1; i <= 3; i++) send(25'(i));
        chk("t1_no_word_yet", bus.m_valid, 0);
        do_start(5'd3, 8'd2, 8'd2, 16'h5555);
        send(25'd4);
        chk("t1_latency_valid", bus.m_valid, 1);
        chk("t1_head_data", bus.m_data, 32'h04030201);
        for (int i = 5; i <= 8; i++) send(25'(i));
        wait_done(prev);
        chk("t1_count", wq.size(), 2);
        chk_word(0, 1'b0, 16'h0100, 32'h04030201);
        chk_word(1, 1'b1, 16'h0101, 32'h08070605);
        chk("t1_done_latency", done_cyc - last_hs_cyc, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_stall_end", stall, 1);

        // two rows of 5: partial words never span rows
        wq.delete();
        prev = done_cnt;
        do_start(5'd0, 8'd5, 8'd2, 16'h0200);
        for (int i = 1; i <= 10; i++) send(25'(i));
        wait_done(prev);
        chk("t2_count", wq.size(), 4);
        chk_word(0, 1'b0, 16'h0200, 32'h04030201);
        chk_word(1, 1'b0, 16'h0201, 32'h00000005);
        chk_word(2, 1'b0, 16'h0202, 32'h09080706);
        chk_word(3, 1'b1, 16'h0203, 32'h0000000A);

        // quantization: saturate, plain shift, MSB set, plain shift
        wq.delete();
        prev = done_cnt;
        do_start(5'd4, 8'd4, 8'd1, 16'h0300);
        send(25'h0001000);
        send(25'h00000F0);
        send(25'h1000000);
        send(25'h0000AB0);
        wait_done(prev);
        chk("t3_count", wq.size(), 1);
        chk_word(0, 1'b1, 16'h0300, 32'hAB000FFF);

        // back-pressure: FIFO fills after 16 elements, head held stable
        bus.m_ready = 1'b0;
        wq.delete();
        prev = done_cnt;
        do_start(5'd0, 8'd20, 8'd1, 16'h0400);
        for (int i = 0; i < 15; i++) send(25'(8'h10 + i));
        chk("t4_stall_before_full", stall, 0);
        send(25'h1F);
        chk("t4_stall_full", stall, 1);
        chk("t4_valid_full", bus.m_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_hold_data", bus.m_data, 32'h13121110);
        chk("t4_hold_addr", bus.m_addr, 16'h0400);
        chk("t4_hold_stall", stall, 1);
        bus.m_ready = 1'b1;
        for (int i = 16; i < 20; i++) send(25'(8'h10 + i));
        wait_done(prev);
        chk("t4_count", wq.size(), 5);
        chk_word(0, 1'b0, 16'h0400, 32'h13121110);
        chk_word(1, 1'b0, 16'h0401, 32'h17161514);
        chk_word(2, 1'b0, 16'h0402, 32'h1B1A1918);
        chk_word(3, 1'b0, 16'h0403, 32'h1F1E1D1C);
        chk_word(4, 1'b1, 16'h0404, 32'h23222120);

        // address wrap at 0xFFFF
        wq.delete();
        prev = done_cnt;
        do_start(5'd0, 8'd12, 8'd1, 16'hFFFF);
        for (int i = 1; i <= 12; i++) send(25'(i));
        wait_done(prev);
        chk("t5_count", wq.size(), 3);
        chk_word(0, 1'b0, 16'hFFFF, 32'h04030201);
        chk_word(1, 1'b0, 16'h0000, 32'h08070605);
        chk_word(2, 1'b1, 16'h0001, 32'h0C0B0A09);

        // reset mid-row with a full FIFO, then a clean tile
        bus.m_ready = 1'b0;
        wq.delete();
        prev = done_cnt;
        do_start(5'd0, 8'd20, 8'd2, 16'h0600);
        for (int i = 0; i < 16; i++) send(25'(8'h30 + i));
        chk("t6_full_stall", stall, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_rst_valid", bus.m_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_stall", stall, 1);
        chk("t6_rst_addr", bus.m_addr, 0);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_nothing_emitted", wq.size(), 0);
        chk("t6_no_done", done_cnt - prev, 0);
        do_start(5'd0, 8'd4, 8'd1, 16'h0700);
        for (int i = 0; i < 4; i++) send(25'(8'h21 + i));
        wait_done(prev);
        chk("t6_count", wq.size(), 1);
        chk_word(0, 1'b1, 16'h0700, 32'h24232221);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 Parameter: data_width, 25, width of the ReLU'd partial-sum stream.
REQ-002 Parameter: fifo_depth, 4, output word FIFO entries (power of two).
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: start  in  1  one-cycle pulse; latches config and starts a tile drain.
REQ-006 Port: cfg_shift  in  5  requantization right-shift.
REQ-007 Port: cfg_row_len  in  8  elements per row, 1..255.
REQ-008 Port: cfg_num_rows  in  8  rows per tile, 1..255.
REQ-009 Port: cfg_base_addr  in  16  first output word address.
REQ-010 Port: in_data  in  data_width  partial-sum element, non-negative after ReLU.
REQ-011 Port: in_valid  in  1  in_data valid this cycle.
REQ-012 Port: stall  out  1  back-pressure to the psum pipeline; element accepted only when in_valid && !stall.
REQ-013 Port: m_data  out  32  packed output word, byte 0 = first element.
REQ-014 Port: m_addr  out  16  word address of m_data.
REQ-015 Port: m_valid / m_ready  out / in  1 / 1  valid-ready handshake to output memory writer.
REQ-016 Port: m_last  out  1  marks the final word of the tile.
REQ-017 Port: busy / done  out / out  1 / 1  drain in progress / one-cycle completion pulse.

Function
REQ-018 FSM states IDLE, RUN, FLUSH; IDLE->RUN on start; RUN->FLUSH after the last element of the last row is accepted; FLUSH->IDLE on handshake of the m_last word.
REQ-019 start while busy is ignored; config is latched only on IDLE start.
REQ-020 busy is high in RUN and FLUSH; done pulses high for exactly one cycle, the cycle after the m_last handshake.
REQ-021 stall is high in IDLE, in FLUSH, and whenever the output FIFO is full; there is no same-cycle bypass of a full FIFO by m_ready.
REQ-022 Quantize each accepted element: q = in_data >> cfg_shift, saturated to 255 if the result exceeds 8 bits; a set in_data MSB yields 0.
REQ-023 Byte lane counter 0..3 fills m_data lanes in order; a word is pushed into the FIFO on the edge when lane 3 is accepted.
REQ-024 Column counter 0..cfg_row_len-1; on the last column a partial word is pushed, unused upper lanes are zero, and the lane counter resets to 0; words never span rows.
REQ-025 Word address starts at cfg_base_addr and increments by 1 per pushed word, wrapping modulo 2^16.
REQ-026 m_last is set on the word pushed for the last element of the last row, stored in the FIFO alongside data and address.
REQ-027 The FIFO head drives m_data/m_addr/m_last, m_valid = !empty, pop on m_valid && m_ready; push and pop in the same cycle keep the count unchanged.
REQ-028 Latency from acceptance of a word-completing element to m_valid at an empty FIFO is exactly 1 cycle.
REQ-029 m_data, m_addr and m_last are stable while m_valid && !m_ready.

Reset
REQ-030 rst_n low at a clock edge: FSM to IDLE; all counters, FIFO pointers and count to 0; m_valid, m_last, busy and done to 0; stall to 1; m_data and m_addr to 0.
REQ-031 Reset mid-tile discards all buffered words with no partial-word emission.

Structure
REQ-032 Shared package holds the FSM state enum, the output byte width (8) and the pack factor (4).
REQ-033 One sub-module, drain_fifo: synchronous fifo_depth x 49-bit FIFO {last, addr, data} with full and empty flags.

Verification
REQ-034 row_len=8, rows=1, shift=0, inputs 1..8, m_ready=1 -> two words 0x04030201 @base and 0x08070605 @base+1, m_last on the second, done 1 cycle later.
REQ-035 row_len=5, rows=2, shift=0 -> four words; words 2 and 4 are 0x00000005 / 0x0000000A-pattern partial words with upper lanes zero; addresses base..base+3.
REQ-036 shift=4, in_data=0x1000 -> byte 0xFF (saturated); in_data=0x00F0 -> 0x0F; in_data with MSB set -> 0x00.
REQ-037 m_ready=0, 20 elements streamed -> stall rises after the 4th word fills the FIFO, no element lost; release m_ready -> all 5 words emitted in order.
REQ-038 base=0xFFFF, three words -> addresses 0xFFFF, 0x0000, 0x0001.
REQ-039 rst_n asserted mid-row with a full FIFO -> next cycle m_valid=0, busy=0, stall=1; a new start drains cleanly from cfg_base_addr.
